// File: rtl/vigna_pkg.sv
// Shared vigna core definitions: data widths, fetch-entry layout and base opcodes.
package vigna_pkg;
  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } fetch_entry_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/vigna_prefetch_if.sv
// Prefetch bundle: instruction bus to memory, instruction stream to decoder, redirect from execute.
interface vigna_prefetch_if;
  import vigna_pkg::*;

  logic            i_valid;
  logic            i_ready;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_rdata;
  logic [XLEN-1:0] i_wdata;
  logic [3:0]      i_wstrb;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_addr;
  logic            redir_valid;
  logic [XLEN-1:0] redir_addr;

  modport master (
    output i_valid, i_addr, i_wdata, i_wstrb, inst_valid, inst_data, inst_addr,
    input  i_ready, i_rdata, inst_ready, redir_valid, redir_addr
  );
  modport slave (
    input  i_valid, i_addr, i_wdata, i_wstrb, inst_valid, inst_data, inst_addr,
    output i_ready, i_rdata, inst_ready, redir_valid, redir_addr
  );
endinterface

// File: rtl/vigna_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush; flush wins over push and pop.
module vigna_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push, w_pop;

  assign w_push  = i_push & ~i_flush;
  assign w_pop   = i_pop & ~i_flush & (r_count != '0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_valid = r_count != '0;
  assign o_count = r_count;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/vigna_prefetch.sv
// Sequential instruction prefetcher with redirect flush and single outstanding fetch.
// Optional VIGNA_PREFETCH_ALIGN_CHECK_EN: misaligned redirects halt fetch and raise fetch_misaligned.
module vigna_prefetch import vigna_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000,
  parameter int              DEPTH      = 4,
  parameter int              CNT_W      = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             resetn,
  vigna_prefetch_if.master bus,
  output logic [CNT_W-1:0] occupancy
`ifdef VIGNA_PREFETCH_ALIGN_CHECK_EN
  , output logic           fetch_misaligned
`endif
);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  logic            r_valid, r_drop;
  logic [XLEN-1:0] r_addr, r_fetch_pc;
  logic            w_resp, w_redir, w_push, w_pop, w_head_valid, w_halt;
  logic [XLEN-1:0] w_redir_pc;
  logic [CNT_W:0]  w_occ_ext, w_occ_after;
  fetch_entry_t    w_wentry, w_rentry;

  assign w_redir     = bus.redir_valid;
  assign w_redir_pc  = word_align(bus.redir_addr);
  assign w_resp      = r_valid & bus.i_ready;
  assign w_push      = w_resp & ~r_drop & ~w_redir;
  assign w_pop       = w_head_valid & bus.inst_ready & ~w_redir;
  assign w_occ_ext   = {1'b0, occupancy};
  assign w_occ_after = w_occ_ext + (CNT_W+1)'(w_push) - (CNT_W+1)'(w_pop);

`ifdef VIGNA_PREFETCH_ALIGN_CHECK_EN
  logic r_mis;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      r_mis <= 1'b0;
    else if (w_redir) r_mis <= bus.redir_addr[1:0] != 2'b00;
  end
  assign w_halt           = r_mis;
  assign fetch_misaligned = r_mis;
`else
  assign w_halt = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid    <= 1'b0;
      r_addr     <= RESET_ADDR;
      r_fetch_pc <= RESET_ADDR;
      r_drop     <= 1'b0;
    end else if (w_redir) begin
      r_fetch_pc <= w_redir_pc;
      // a stalled request must keep its address; its data is discarded on arrival
      if (r_valid && !bus.i_ready) begin
        r_drop <= 1'b1;
      end else begin
        r_valid <= 1'b0;
        r_drop  <= 1'b0;
      end
    end else if (w_resp) begin
      r_drop <= 1'b0;
      if (w_occ_after < DEPTH_C && !w_halt) begin
        r_addr     <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + XLEN'(INSN_BYTES);
      end else begin
        r_valid <= 1'b0;
      end
    end else if (!r_valid && w_occ_ext < DEPTH_C && !w_halt) begin
      r_valid    <= 1'b1;
      r_addr     <= r_fetch_pc;
      r_fetch_pc <= r_fetch_pc + XLEN'(INSN_BYTES);
    end
  end

  assign w_wentry = '{addr: r_addr, data: bus.i_rdata};

  vigna_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t)),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_wdata (w_wentry),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .o_rdata (w_rentry),
    .o_valid (w_head_valid),
    .o_count (occupancy)
  );

  assign bus.i_valid    = r_valid;
  assign bus.i_addr     = r_addr;
  assign bus.i_wdata    = '0;
  assign bus.i_wstrb    = '0;
  assign bus.inst_valid = w_head_valid;
  assign bus.inst_addr  = w_rentry.addr;
  assign bus.inst_data  = w_rentry.data;
endmodule

// File: doc/vigna_prefetch.md
Name: vigna_prefetch

Overview:
- Parametrised instruction-fetch front end for the next-generation vigna core. It replaces the core's single-word, one-fetch-per-instruction loop.
- Issues sequential word fetches on the existing valid/ready instruction bus and buffers returned words with their addresses in a DEPTH-entry FIFO.
- Presents buffered words to the decoder over a valid/ready handshake.
- The execute stage redirects it on taken branches and jumps, which flushes stale words and any fetch in flight.

Parameters:
- RESET_ADDR, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, FIFO entries; power of two, legal range 2..16.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- i_valid  output  1  fetch request valid.
- i_ready  input  1  memory accepts the request; i_rdata is valid in the same cycle.
- i_addr  output  32  fetch address, always word aligned.
- i_rdata  input  32  fetched word.
- i_wdata  output  32  tied to 0.
- i_wstrb  output  4  tied to 0.
- inst_valid  output  1  FIFO head valid.
- inst_ready  input  1  decoder pops the head.
- inst_data  output  32  head instruction word.
- inst_addr  output  32  head instruction address.
- redir_valid  input  1  one-cycle redirect strobe.
- redir_addr  input  32  redirect target.
- occupancy  output  CNT_W  number of valid FIFO entries.
- fetch_misaligned  output  1  present only when the optional feature is enabled.

Behaviour:
- Reset (asynchronous, while resetn=0):
  - i_valid=0, i_addr=RESET_ADDR, inst_valid=0, occupancy=0.
  - fetch_pc=RESET_ADDR, drop flag=0.
- Bus rule: while i_valid=1 and i_ready=0, i_addr must stay stable. At most one request is outstanding.
- Issue:
  - A request is issued when no request is outstanding, occupancy<DEPTH and no redirect occurs that cycle.
  - On issue: i_valid<=1, i_addr<=fetch_pc, fetch_pc<=fetch_pc+4.
  - The first request follows the first clk edge after resetn rises, with i_addr=RESET_ADDR.
- Response (i_valid & i_ready):
  - Push {i_addr, i_rdata} into the FIFO, unless drop=1 or redir_valid=1 in the same cycle; in those cases the word is discarded and drop is cleared.
- Back-to-back fetch:
  - In the response cycle, if occupancy+1-pop<DEPTH and there is no redirect, i_valid stays 1 and i_addr<=fetch_pc.
  - Sustained throughput is 1 word/cycle when memory is zero-wait.
  - Otherwise i_valid<=0.
- FIFO:
  - Registered storage; no bypass. A word is visible on inst_* one cycle after its i_ready.
  - inst_valid = occupancy!=0. Pop when inst_valid & inst_ready.
  - Push and pop in the same cycle leaves occupancy unchanged.
  - Pointers wrap modulo DEPTH.
  - Push is never presented when full, because issue is gated on free space.
- Redirect (priority over push and pop):
  - occupancy<=0, pointers reset, fetch_pc<=redir_addr with bits [1:0] cleared.
  - A pop in the same cycle is ignored.
  - If a request is outstanding and not completing this cycle: i_valid/i_addr are held, drop<=1, and the next request goes to the new target after that response.
  - If no request is outstanding: a request to the new target issues in the following cycle.
  - A second redirect before the dropped response arrives updates fetch_pc only; the single drop flag remains sufficient.
- Wrap-around: fetch_pc increments modulo 2^32.

Optional Feature:
- Macro: VIGNA_PREFETCH_ALIGN_CHECK_EN.
- With the macro defined:
  - A redirect with redir_addr[1:0]!=0 still flushes the FIFO, then sets fetch_misaligned=1 (held) and issues no further requests.
  - A later aligned redirect clears fetch_misaligned and resumes fetching.
  - fetch_misaligned resets to 0.
- Without the macro: the fetch_misaligned port is absent and redir_addr[1:0] is silently forced to 00.

Decomposition:
- Package vigna_pkg: XLEN=32, INSN_BYTES=4, and the fetch-entry struct {addr, data}. The core's opcode constants move into the same package.
- Sub-module vigna_sync_fifo: parametrised DEPTH x width storage with push, pop, flush and count. It is reused later for the load/store queue.

Test Plan:
- Zero-wait memory (i_ready=1 constant), inst_ready=1 → i_addr sequence 0,4,8,...; inst_valid continuous from cycle 3; one instruction per cycle.
- inst_ready=0, DEPTH=4 → exactly 4 fetches (0..C), then i_valid=0 and occupancy=4. Raising inst_ready resumes with addr 0x10.
- Request to 0x8 stalled (i_ready=0 for 3 cycles), redirect to 0x100 in cycle 1 → 0x8 is held until accepted and its data is never seen on inst_*; next i_addr=0x100; first inst_addr=0x100.
- Redirect to 0x40 in the same cycle as a pop and a response → occupancy=0 next cycle, the response is dropped, and the next request is 0x40.
- Reset asserted mid-fetch (asynchronously, between edges) → i_valid=0 and occupancy=0 immediately; after release the first i_addr is RESET_ADDR.
- With VIGNA_PREFETCH_ALIGN_CHECK_EN: redirect to 0x102 → fetch_misaligned=1 and no i_valid; then redirect to 0x200 → flag clears and i_addr=0x200.
